// File: rtl/conv_pkg.sv
// conv_pkg: state encoding and geometry helper shared by the convolution sequencer slice.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Output edge length of a valid-padding (no-padding) convolution.
  function automatic int out_size(input int inSize, input int kSize);
    return inSize - kSize + 1;
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if: input read bus (pixel + weight memories) and output write handshake.
interface conv_sequencer_if #(
  parameter int INPUT_SIZE     = 32,
  parameter int INPUT_CHANNELS = 3,
  parameter int KERNEL_SIZE    = 3,
  parameter int OUT_CHANNELS   = 6,
  parameter int PX_SIZE        = 8
);
  import conv_pkg::*;

  localparam int OUT_SIZE = out_size(INPUT_SIZE, KERNEL_SIZE);
  localparam int ROW_W    = $clog2(INPUT_SIZE);
  localparam int CH_W     = $clog2(INPUT_CHANNELS);
  localparam int OC_W     = $clog2(OUT_CHANNELS);
  localparam int ORW      = $clog2(OUT_SIZE);
  localparam int WA_W     = $clog2(OUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE * INPUT_CHANNELS);

  logic                       rd_en;
  logic [ROW_W-1:0]           rd_row;
  logic [ROW_W-1:0]           rd_col;
  logic [CH_W-1:0]            rd_ch;
  logic [PX_SIZE-1:0]         px_data;
  logic [WA_W-1:0]            w_addr;
  logic signed [PX_SIZE-1:0]  w_data;
  logic                       wr_valid;
  logic                       wr_ready;
  logic [OC_W-1:0]            wr_ch;
  logic [ORW-1:0]             wr_row;
  logic [ORW-1:0]             wr_col;
  logic [PX_SIZE-1:0]         wr_data;

  // Sequencer side: issues reads and offers output pixels.
  modport master (
    output rd_en, rd_row, rd_col, rd_ch, w_addr,
    output wr_valid, wr_ch, wr_row, wr_col, wr_data,
    input  px_data, w_data, wr_ready
  );

  // Memory / feature-map side: answers reads and accepts output pixels.
  modport slave (
    input  rd_en, rd_row, rd_col, rd_ch, w_addr,
    input  wr_valid, wr_ch, wr_row, wr_col, wr_data,
    output px_data, w_data, wr_ready
  );

endinterface

// File: rtl/conv_mac.sv
// conv_mac: single signed MAC accumulator plus the ReLU / shift / saturate output stage.
module conv_mac #(
  parameter int PX_SIZE   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int SHIFT     = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_rdEn,
  input  logic [PX_SIZE-1:0]        i_pxData,
  input  logic signed [PX_SIZE-1:0] i_wData,
  output logic [PX_SIZE-1:0]        o_wrData
);
  import conv_pkg::*;

  localparam int PROD_W = 2 * PX_SIZE + 1;
  localparam logic signed [ACC_WIDTH-1:0] PX_MAX = ACC_WIDTH'((1 << PX_SIZE) - 1);

  logic                        r_accEn;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [PROD_W-1:0]    w_prod;
  logic signed [ACC_WIDTH-1:0] w_prodExt;
  logic signed [ACC_WIDTH-1:0] w_shifted;

  // Unsigned pixel times signed weight, sign-extended to the accumulator width.
  always_comb begin
    w_prod    = $signed({1'b0, i_pxData}) * i_wData;
    w_prodExt = {{(ACC_WIDTH - PROD_W){w_prod[PROD_W-1]}}, w_prod};
  end

  // Memory data lands one cycle after the read strobe, so the add enable is the strobe delayed by one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_accEn <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_accEn <= i_rdEn;
      if (i_clear) begin
        r_acc <= '0;
      end else if (r_accEn) begin
        r_acc <= r_acc + w_prodExt;
      end
    end
  end

  // Negative sums clip to zero; positive sums are scaled down and clamped to the pixel range.
  always_comb begin
    w_shifted = r_acc >>> SHIFT;
    if (r_acc[ACC_WIDTH-1]) begin
      o_wrData = '0;
    end else if (w_shifted > PX_MAX) begin
      o_wrData = PX_MAX[PX_SIZE-1:0];
    end else begin
      o_wrData = w_shifted[PX_SIZE-1:0];
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: walks output channel/row/column in raster order, streams K*K*C taps through
// one MAC per output pixel, and hands each finished pixel downstream.
module conv_sequencer #(
  parameter int INPUT_SIZE     = 32,
  parameter int INPUT_CHANNELS = 3,
  parameter int KERNEL_SIZE    = 3,
  parameter int OUT_CHANNELS   = 6,
  parameter int PX_SIZE        = 8,
  parameter int ACC_WIDTH      = 24,
  parameter int SHIFT          = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  conv_sequencer_if.master bus
);
  import conv_pkg::*;

  localparam int OUT_SIZE = out_size(INPUT_SIZE, KERNEL_SIZE);
  localparam int TAPS     = KERNEL_SIZE * KERNEL_SIZE * INPUT_CHANNELS;
  localparam int ROW_W    = $clog2(INPUT_SIZE);
  localparam int CH_W     = $clog2(INPUT_CHANNELS);
  localparam int OC_W     = $clog2(OUT_CHANNELS);
  localparam int ORW      = $clog2(OUT_SIZE);
  localparam int KW_W     = $clog2(KERNEL_SIZE);
  localparam int WA_W     = $clog2(OUT_CHANNELS * TAPS);

  localparam logic [KW_W-1:0] KMAX  = KW_W'(KERNEL_SIZE - 1);
  localparam logic [CH_W-1:0] CMAX  = CH_W'(INPUT_CHANNELS - 1);
  localparam logic [ORW-1:0]  OMAX  = ORW'(OUT_SIZE - 1);
  localparam logic [OC_W-1:0] OCMAX = OC_W'(OUT_CHANNELS - 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_rdEn;
  logic             r_wrValid;
  logic [ROW_W-1:0] r_rdRow;
  logic [ROW_W-1:0] r_rdCol;
  logic [CH_W-1:0]  r_ic;
  logic [KW_W-1:0]  r_kh;
  logic [KW_W-1:0]  r_kw;
  logic [WA_W-1:0]  r_wAddr;
  logic [WA_W-1:0]  r_wBase;
  logic [OC_W-1:0]  r_oc;
  logic [ORW-1:0]   r_r;
  logic [ORW-1:0]   r_c;

  logic             w_startAccept;
  logic             w_handshake;
  logic             w_lastTap;
  logic             w_lastC;
  logic             w_lastR;
  logic             w_lastOc;
  logic             w_lastPixel;
  logic [ORW-1:0]   w_nextC;
  logic [ORW-1:0]   w_nextR;
  logic [OC_W-1:0]  w_nextOc;
  logic [WA_W-1:0]  w_nextBase;
  logic [PX_SIZE-1:0] w_macData;

  assign w_startAccept = (r_state == IDLE) && start && !r_done;
  assign w_handshake   = r_wrValid && bus.wr_ready;

  // Decode the end of the tap walk and the raster position of the next output pixel.
  always_comb begin
    w_lastTap   = (r_kh == KMAX) && (r_kw == KMAX) && (r_ic == CMAX);
    w_lastC     = (r_c == OMAX);
    w_lastR     = (r_r == OMAX);
    w_lastOc    = (r_oc == OCMAX);
    w_lastPixel = w_lastC && w_lastR && w_lastOc;
    w_nextC     = w_lastC ? '0 : r_c + ORW'(1);
    w_nextR     = r_r;
    w_nextOc    = r_oc;
    w_nextBase  = r_wBase;
    if (w_lastC) begin
      w_nextR = w_lastR ? '0 : r_r + ORW'(1);
    end
    if (w_lastC && w_lastR) begin
      w_nextOc   = w_lastOc ? '0 : r_oc + OC_W'(1);
      w_nextBase = w_lastOc ? '0 : r_wBase + WA_W'(TAPS);
    end
  end

  // Control FSM; weights of one kernel are contiguous, so the weight address simply counts up per tap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdEn    <= 1'b0;
      r_wrValid <= 1'b0;
      r_rdRow   <= '0;
      r_rdCol   <= '0;
      r_ic      <= '0;
      r_kh      <= '0;
      r_kw      <= '0;
      r_wAddr   <= '0;
      r_wBase   <= '0;
      r_oc      <= '0;
      r_r       <= '0;
      r_c       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_startAccept) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_rdEn  <= 1'b1;
            r_ic    <= '0;
            r_kh    <= '0;
            r_kw    <= '0;
            r_oc    <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_rdRow <= '0;
            r_rdCol <= '0;
            r_wAddr <= '0;
            r_wBase <= '0;
          end
        end
        RUN: begin
          if (w_lastTap) begin
            r_state <= DRAIN;
            r_rdEn  <= 1'b0;
          end else begin
            r_wAddr <= r_wAddr + WA_W'(1);
            if (r_ic == CMAX) begin
              r_ic <= '0;
              if (r_kw == KMAX) begin
                r_kw    <= '0;
                r_kh    <= r_kh + KW_W'(1);
                r_rdCol <= ROW_W'(r_c);
                r_rdRow <= r_rdRow + ROW_W'(1);
              end else begin
                r_kw    <= r_kw + KW_W'(1);
                r_rdCol <= r_rdCol + ROW_W'(1);
              end
            end else begin
              r_ic <= r_ic + CH_W'(1);
            end
          end
        end
        DRAIN: begin
          r_state   <= WRITE;
          r_wrValid <= 1'b1;
        end
        WRITE: begin
          if (w_handshake) begin
            r_wrValid <= 1'b0;
            r_c       <= w_nextC;
            r_r       <= w_nextR;
            r_oc      <= w_nextOc;
            r_wBase   <= w_nextBase;
            r_wAddr   <= w_nextBase;
            r_rdRow   <= ROW_W'(w_nextR);
            r_rdCol   <= ROW_W'(w_nextC);
            r_ic      <= '0;
            r_kh      <= '0;
            r_kw      <= '0;
            if (w_lastPixel) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_rdEn  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  conv_mac #(
    .PX_SIZE   (PX_SIZE),
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_startAccept || w_handshake),
    .i_rdEn   (r_rdEn),
    .i_pxData (bus.px_data),
    .i_wData  (bus.w_data),
    .o_wrData (w_macData)
  );

  assign busy         = r_busy;
  assign done         = r_done;
  assign bus.rd_en    = r_rdEn;
  assign bus.rd_row   = r_rdRow;
  assign bus.rd_col   = r_rdCol;
  assign bus.rd_ch    = r_ic;
  assign bus.w_addr   = r_wAddr;
  assign bus.wr_valid = r_wrValid;
  assign bus.wr_ch    = r_oc;
  assign bus.wr_row   = r_r;
  assign bus.wr_col   = r_c;
  assign bus.wr_data  = w_macData;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: reduced-size layer (6x6x2 input, 3x3 kernels, 2 output channels, shift 2)
// checked pixel-by-pixel against a direct convolution of the bench's own image and weight arrays.
module tb_conv_sequencer;
  import conv_pkg::*;

  localparam int IS      = 6;
  localparam int C       = 2;
  localparam int K       = 3;
  localparam int OC      = 2;
  localparam int PX      = 8;
  localparam int ACC     = 24;
  localparam int SH      = 2;
  localparam int OS      = IS - K + 1;
  localparam int TAPS    = K * K * C;
  localparam int NPIX    = OC * OS * OS;
  localparam int PIX_CYC = TAPS + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
  int   checks = 0;
  int   failures = 0;

  logic [7:0]        img [IS][IS][C];
  logic signed [7:0] wgt [OC*K*K*C];

  conv_sequencer_if #(
    .INPUT_SIZE(IS), .INPUT_CHANNELS(C), .KERNEL_SIZE(K), .OUT_CHANNELS(OC), .PX_SIZE(PX)
  ) bus ();

  conv_sequencer #(
    .INPUT_SIZE(IS), .INPUT_CHANNELS(C), .KERNEL_SIZE(K), .OUT_CHANNELS(OC),
    .PX_SIZE(PX), .ACC_WIDTH(ACC), .SHIFT(SH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port memories with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.px_data <= img[bus.rd_row][bus.rd_col][bus.rd_ch];
      bus.w_data  <= wgt[bus.w_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Direct convolution + ReLU + shift + clamp for one output pixel.
  function automatic int refPixel(input int oc, input int r, input int c);
    int sum;
    sum = 0;
    for (int kh = 0; kh < K; kh++)
      for (int kw = 0; kw < K; kw++)
        for (int ic = 0; ic < C; ic++)
          sum += int'(img[r+kh][c+kw][ic]) * int'(wgt[((oc*K + kh)*K + kw)*C + ic]);
    if (sum < 0) return 0;
    sum = sum >> SH;
    return (sum > 255) ? 255 : sum;
  endfunction

  // mode 0: constant val, 1: ramp depending on row/col/channel, 2: random 0..val
  task automatic setImage(input int mode, input int val);
    for (int r = 0; r < IS; r++)
      for (int c = 0; c < IS; c++)
        for (int ch = 0; ch < C; ch++)
          case (mode)
            0:       img[r][c][ch] = 8'(val);
            1:       img[r][c][ch] = 8'(r + 16*c + 64*ch);
            default: img[r][c][ch] = 8'($urandom_range(0, val));
          endcase
  endtask

  // mode 0: constant val, 1: random -val..val, 2: one nonzero tap per kernel
  task automatic setWeights(input int mode, input int val);
    int t;
    for (int i = 0; i < OC*K*K*C; i++) begin
      case (mode)
        0:       t = val;
        1:       t = int'($urandom_range(0, 2*val)) - val;
        default: t = 0;
      endcase
      wgt[i] = 8'(t);
    end
    if (mode == 2) begin
      wgt[((0*K + 2)*K + 0)*C + 0] = 8'(val);
      wgt[((1*K + 0)*K + 2)*C + 1] = 8'(val);
    end
  endtask

  // One full layer pass with optional stall on the first output, stray starts, and a start held over done.
  task automatic applyStimulus(input string name, input int stallLen, input bit startPulses, input bit startOnDone);
    int cyc, pix, stalled, doneCyc, oc, r, c;
    bit gotDone;
    @(negedge clk);
    checkOutput({name, "_idleBeforeStart"}, 32'(busy), 0);
    start = 1'b1;
    bus.wr_ready = 1'b1;
    @(posedge clk);
    cyc = 0; pix = 0; stalled = 0; doneCyc = 0; gotDone = 1'b0;
    while (!gotDone && cyc < NPIX*PIX_CYC + stallLen + 50) begin
      @(negedge clk);
      cyc++;
      start = startPulses && (cyc == 3 || cyc == TAPS + 2 || cyc == 3*PIX_CYC + 1);
      if (cyc == 1) checkOutput({name, "_busyRdFirst"}, 32'({busy, bus.rd_en}), 3);
      if (bus.wr_valid) begin
        oc = pix / (OS*OS);
        r  = (pix / OS) % OS;
        c  = pix % OS;
        checkOutput({name, "_wrData"}, 32'(bus.wr_data), 32'(refPixel(oc, r, c)));
        checkOutput({name, "_wrPos"},
                    32'(bus.wr_ch) * 256 + 32'(bus.wr_row) * 16 + 32'(bus.wr_col),
                    32'(oc * 256 + r * 16 + c));
        checkOutput({name, "_noReadInWrite"}, 32'(bus.rd_en), 0);
        if (pix == 0 && stalled < stallLen) begin
          bus.wr_ready = 1'b0;
          stalled++;
        end else begin
          bus.wr_ready = 1'b1;
          pix++;
        end
      end else begin
        bus.wr_ready = 1'b1;
      end
      if (done) begin
        gotDone = 1'b1;
        doneCyc = cyc;
        start = startOnDone;
      end
    end
    checkOutput({name, "_doneSeen"}, 32'(gotDone), 1);
    checkOutput({name, "_doneCycle"}, 32'(doneCyc), 32'(NPIX*PIX_CYC + 1 + stallLen));
    checkOutput({name, "_pixCount"}, 32'(pix), 32'(NPIX));
  endtask

  // Pull reset for one cycle in the middle of the first tap walk and confirm the block goes quiet.
  task automatic resetMidRun();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("preReset_rdEn", 32'(bus.rd_en), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midReset_flags", 32'({busy, done, bus.rd_en, bus.wr_valid}), 0);
    checkOutput("midReset_addr", 32'({bus.rd_row, bus.rd_col, bus.rd_ch, bus.w_addr}), 0);
    checkOutput("midReset_wrData", 32'(bus.wr_data), 0);
    for (int i = 0; i < TAPS + 10; i++) begin
      @(negedge clk);
      checkOutput("afterReset_quiet", 32'({busy, done, bus.rd_en, bus.wr_valid}), 0);
    end
  endtask

  initial begin
    bus.wr_ready = 1'b1;
    rst_n = 1'b0;
    start = 1'b0;
    setImage(0, 1);
    setWeights(0, 1);
    repeat (3) @(negedge clk);
    checkOutput("reset_flags", 32'({busy, done, bus.rd_en, bus.wr_valid}), 0);
    checkOutput("reset_addr", 32'({bus.rd_row, bus.rd_col, bus.rd_ch, bus.w_addr}), 0);
    checkOutput("reset_wrPos", 32'({bus.wr_ch, bus.wr_row, bus.wr_col}), 0);
    checkOutput("reset_wrData", 32'(bus.wr_data), 0);
    rst_n = 1'b1;

    $display("[TB] all-ones image and weights");
    applyStimulus("ones", 0, 1'b0, 1'b0);

    $display("[TB] negative weights clip to zero");
    setWeights(0, -1);
    applyStimulus("relu", 0, 1'b0, 1'b0);

    $display("[TB] saturation");
    setImage(0, 255);
    setWeights(0, 127);
    applyStimulus("sat", 0, 1'b0, 1'b0);

    $display("[TB] ramp image with single-tap kernels and a 5-cycle stall");
    setImage(1, 0);
    setWeights(2, 4);
    applyStimulus("ramp", 5, 1'b0, 1'b0);

    $display("[TB] random small values, stray starts, start held across done");
    setImage(2, 31);
    setWeights(1, 8);
    applyStimulus("randSmall", 0, 1'b1, 1'b1);

    $display("[TB] random full range");
    setImage(2, 255);
    setWeights(1, 127);
    applyStimulus("randFull", 0, 1'b0, 1'b0);
    start = 1'b0;

    $display("[TB] reset in the middle of a pass");
    resetMidRun();

    setImage(2, 63);
    setWeights(1, 20);
    applyStimulus("afterReset", 3, 1'b1, 1'b0);
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
